// File: rtl/id_stall_sequencer_pkg.sv
// id_stall_sequencer_pkg: shared state encodings and stall-length constants for the ID interlock
package id_stall_sequencer_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FREEZE = 2'd2} state_t;
    localparam logic [4:0] ZERO_REG          = 5'd0;
    localparam logic [1:0] LOAD_USE_STALL    = 2'd1;
    localparam logic [1:0] LOAD_BRANCH_STALL = 2'd2;
    localparam logic [1:0] ALU_BRANCH_STALL  = 2'd1;
endpackage

// File: rtl/id_stall_sequencer_if.sv
// id_stall_sequencer_if: hazard inputs from the pipeline and the register enable/clear controls back to it
interface id_stall_sequencer_if;
    logic [4:0] rs_id;
    logic [4:0] rt_id;
    logic       uses_rs_id;
    logic       uses_rt_id;
    logic       branch_id;
    logic       taken_id;
    logic [4:0] dest_ex;
    logic       reg_write_ex;
    logic       mem_read_ex;
    logic [4:0] dest_mem;
    logic       mem_read_mem;
    logic       ext_hold;
    logic       stall_pc;
    logic       stall_id;
    logic       bubble_id_ex;
    logic       flush_if_id;
    logic       freeze;
    logic       busy;
    modport master (
        output rs_id, rt_id, uses_rs_id, uses_rt_id, branch_id, taken_id,
               dest_ex, reg_write_ex, mem_read_ex, dest_mem, mem_read_mem, ext_hold,
        input  stall_pc, stall_id, bubble_id_ex, flush_if_id, freeze, busy
    );
    modport slave (
        input  rs_id, rt_id, uses_rs_id, uses_rt_id, branch_id, taken_id,
               dest_ex, reg_write_ex, mem_read_ex, dest_mem, mem_read_mem, ext_hold,
        output stall_pc, stall_id, bubble_id_ex, flush_if_id, freeze, busy
    );
endinterface

// File: rtl/id_stall_sequencer_hazard_compare.sv
// id_hazard_compare: combinational stall-length calculation from ID sources vs EX/MEM destinations
module id_hazard_compare
    import id_stall_sequencer_pkg::*;
#(
    parameter int MAX_STALL  = 2,
    parameter int ZERO_GUARD = 1,
    localparam int CW = $clog2(MAX_STALL + 1)
) (
    input  logic [4:0]    rs_id,
    input  logic [4:0]    rt_id,
    input  logic          uses_rs_id,
    input  logic          uses_rt_id,
    input  logic          branch_id,
    input  logic [4:0]    dest_ex,
    input  logic          reg_write_ex,
    input  logic          mem_read_ex,
    input  logic [4:0]    dest_mem,
    input  logic          mem_read_mem,
    output logic [CW-1:0] need
);
    logic       m_ex;
    logic       m_mem;
    logic [1:0] raw;
    always_comb begin
        m_ex  = !((ZERO_GUARD != 0) && dest_ex == ZERO_REG) &&
                ((dest_ex == rs_id && uses_rs_id) || (dest_ex == rt_id && uses_rt_id));
        m_mem = !((ZERO_GUARD != 0) && dest_mem == ZERO_REG) &&
                ((dest_mem == rs_id && uses_rs_id) || (dest_mem == rt_id && uses_rt_id));
        raw   = (mem_read_ex && m_ex && branch_id)                 ? LOAD_BRANCH_STALL :
                (mem_read_ex && m_ex)                              ? LOAD_USE_STALL    :
                (reg_write_ex && !mem_read_ex && m_ex && branch_id) ? ALU_BRANCH_STALL  :
                (mem_read_mem && m_mem && branch_id)               ? ALU_BRANCH_STALL  : 2'd0;
        need  = (32'(raw) > MAX_STALL) ? CW'(MAX_STALL) : CW'(raw);
    end
endmodule

// File: rtl/id_stall_sequencer.sv
// id_stall_sequencer: ID-stage interlock FSM sequencing PC/IF-ID hold, ID-EX bubble and IF-ID flush
// STALL_STATS_EN adds stall_cycles / flush_count statistic outputs.
module id_stall_sequencer
    import id_stall_sequencer_pkg::*;
#(
    parameter int MAX_STALL  = 2,
    parameter int ZERO_GUARD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    id_stall_sequencer_if.slave bus
`ifdef STALL_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);
    localparam int CW = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    state_t        state, state_nx;
    logic [CW-1:0] need, cnt, cnt_nx;
    logic          stall, flush, frz;
    id_hazard_compare #(.MAX_STALL(MAX_STALL), .ZERO_GUARD(ZERO_GUARD)) u_cmp (
        .rs_id        (bus.rs_id),
        .rt_id        (bus.rt_id),
        .uses_rs_id   (bus.uses_rs_id),
        .uses_rt_id   (bus.uses_rt_id),
        .branch_id    (bus.branch_id),
        .dest_ex      (bus.dest_ex),
        .reg_write_ex (bus.reg_write_ex),
        .mem_read_ex  (bus.mem_read_ex),
        .dest_mem     (bus.dest_mem),
        .mem_read_mem (bus.mem_read_mem),
        .need         (need)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // Outputs are gated by rst_n so they read 0 while reset is held, even in RUN with a live hazard.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall    = 1'b0;
        flush    = 1'b0;
        frz      = 1'b0;
        if (rst_n) begin
            if (bus.ext_hold) begin
                frz      = 1'b1;
                state_nx = FREEZE;
            end else if (state == FREEZE) begin
                frz      = 1'b1;
                state_nx = (cnt != '0) ? STALL : RUN;
            end else if (state == STALL) begin
                stall    = 1'b1;
                cnt_nx   = cnt - ONE;
                state_nx = (cnt == ONE) ? RUN : STALL;
            end else if (need != '0) begin
                stall    = 1'b1;
                cnt_nx   = need - ONE;
                state_nx = (need > ONE) ? STALL : RUN;
            end else begin
                flush    = bus.taken_id;
            end
        end
    end
    assign bus.stall_pc     = stall;
    assign bus.stall_id     = stall;
    assign bus.bubble_id_ex = stall;
    assign bus.flush_if_id  = flush;
    assign bus.freeze       = frz;
    assign bus.busy         = state != RUN;
`ifdef STALL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, stall};
            flush_count  <= flush_count + {31'd0, flush};
        end
    end
`endif
endmodule

// File: tb/tb_id_stall_sequencer.sv
// tb_id_stall_sequencer: directed scoreboard bench for the ID interlock sequencer
module tb_id_stall_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    id_stall_sequencer_if bus();
`ifdef STALL_STATS_EN
    logic [31:0] stall_cycles, flush_count;
`endif
    id_stall_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef STALL_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );
    typedef struct {
        string      tag;
        logic [5:0] v;
    } exp_t;
    exp_t sb[$];
    int n_assert = 0;
    int n_fail = 0;
    int sc = 0;
    int fc = 0;
    logic [5:0] last_v = '0;
    // {stall_pc, stall_id, bubble_id_ex, flush_if_id, freeze, busy}
    wire [5:0] obs = {bus.stall_pc, bus.stall_id, bus.bubble_id_ex, bus.flush_if_id, bus.freeze, bus.busy};
    localparam logic [5:0] IDLE = 6'b000000, BUB = 6'b111000, BUBB = 6'b111001,
                           FLU = 6'b000100, FRZ = 6'b000010, FRZB = 6'b000011;

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                         input logic br, input logic tk, input logic [4:0] dex, input logic rw,
                         input logic mr, input logic [4:0] dm, input logic mm, input logic hold);
        bus.rs_id = rs; bus.rt_id = rt; bus.uses_rs_id = urs; bus.uses_rt_id = urt;
        bus.branch_id = br; bus.taken_id = tk; bus.dest_ex = dex; bus.reg_write_ex = rw;
        bus.mem_read_ex = mr; bus.dest_mem = dm; bus.mem_read_mem = mm; bus.ext_hold = hold;
    endtask
    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask
    task automatic expect_out(input string tag, input logic [5:0] v);
        sb.push_back('{tag, v});
        last_v = v;
    endtask
    task automatic check_sb();
        #2;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_assert++;
            assert (obs === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
            end
        end
    endtask
    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic cyc();
        check_sb();
        @(posedge clk);
        if (rst_n) begin
            sc += int'(last_v[3]);
            fc += int'(last_v[2]);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        expect_out("reset_gated", IDLE);
        check_sb();
        @(negedge clk);
        rst_n = 1'b1;
        idle(); expect_out("run_idle", IDLE); cyc();
        // load-use, non-branch
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("load_use", BUB); cyc();
        idle(); expect_out("load_use_done", IDLE); cyc();
        // load-use with source unused
        drive(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("unused_src", IDLE); cyc();
        // load-to-branch: two bubbles, second one in STALL
        drive(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("ld_br_1", BUB); cyc();
        drive(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("ld_br_2", BUBB); cyc();
        idle(); expect_out("ld_br_done", IDLE); cyc();
        // ALU-to-branch and zero-register guard
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("alu_br", BUB); cyc();
        drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("alu_br_r0", IDLE); cyc();
        // ALU result to non-branch needs no stall
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("alu_nonbr", IDLE); cyc();
        // load in MEM feeding a branch
        drive(5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);
        expect_out("mem_ld_br", BUB); cyc();
        // taken branch, no hazard, then taken masked by a stall
        drive(5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("taken", FLU); cyc();
        idle(); expect_out("taken_once", IDLE); cyc();
        drive(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("taken_masked", BUB); cyc();
        // Ext_Hold in the second cycle of a two-cycle stall
        drive(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("frz_stall_1", BUB); cyc();
        bus.ext_hold = 1'b1; expect_out("frz_a", FRZB); cyc();
        expect_out("frz_b", FRZB); cyc();
        bus.ext_hold = 1'b0; expect_out("frz_c", FRZB); cyc();
        expect_out("frz_resume", BUBB); cyc();
        idle(); expect_out("frz_done", IDLE); cyc();
        // Ext_Hold from RUN overrides a hazard; taken during FREEZE is deferred
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
        expect_out("hold_run", FRZ); cyc();
        drive(5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        expect_out("frz_taken", FRZB); cyc();
        expect_out("taken_after", FLU); cyc();
`ifdef STALL_STATS_EN
        check32("stall_cycles", stall_cycles, 32'(sc));
        check32("flush_count", flush_count, 32'(fc));
`endif
        // reset mid-stall
        drive(5'd0, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("rst_stall_1", BUB); cyc();
        expect_out("rst_stall_2", BUBB); check_sb();
        rst_n = 1'b0;
        expect_out("rst_mid", IDLE); check_sb();
`ifdef STALL_STATS_EN
        check32("stall_cycles_rst", stall_cycles, 32'd0);
        check32("flush_count_rst", flush_count, 32'd0);
`endif
        sc = 0; fc = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); expect_out("post_rst", IDLE); cyc();
        drive(5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        expect_out("post_rst_lu", BUB); cyc();
        idle(); expect_out("post_rst_idle", IDLE); cyc();
`ifdef STALL_STATS_EN
        check32("stall_cycles_end", stall_cycles, 32'(sc));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
